// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the conditional two's-complement negate used for operand magnitudes and the product sign fix-up.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Helper works at a fixed wide width; callers size-cast in and out, which limits WIDTH to 32.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? (~x + MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier, one multiplier bit per clock,
// unsigned or two's-complement per operation, with start/busy/done handshake.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic [CNT_W-1:0]   cycles_o
);

    localparam int AW = 2 * WIDTH + 1;

    state_t             state_reg, state_next;
    logic [AW-1:0]      acc_reg, acc_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [CNT_W-1:0]   run_cnt_reg, run_cnt_next;
    logic               neg_reg, neg_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [2*WIDTH-1:0] product_reg, product_next;
    logic [CNT_W-1:0]   cycles_reg, cycles_next;

    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] signed_prod;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            b_reg       <= '0;
            bit_cnt_reg <= '0;
            run_cnt_reg <= '0;
            neg_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
            cycles_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            b_reg       <= b_next;
            bit_cnt_reg <= bit_cnt_next;
            run_cnt_reg <= run_cnt_next;
            neg_reg     <= neg_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            product_reg <= product_next;
            cycles_reg  <= cycles_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        b_next       = b_reg;
        bit_cnt_next = bit_cnt_reg;
        run_cnt_next = run_cnt_reg;
        neg_next     = neg_reg;
        done_next    = 1'b0;
        product_next = product_reg;
        cycles_next  = cycles_reg;

        sa          = signed_i & a_i[WIDTH-1];
        sb          = signed_i & b_i[WIDTH-1];
        abs_a       = WIDTH'(neg_if(MAX_W'(a_i), sa));
        abs_b       = WIDTH'(neg_if(MAX_W'(b_i), sb));
        // Top of ACC is always clear before the add, so the carry has room in bit 2W.
        sum         = acc_reg[AW-1:WIDTH] + {1'b0, b_reg};
        signed_prod = (2*WIDTH)'(neg_if(MAX_W'(acc_reg[2*WIDTH-1:0]), neg_reg));

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    neg_next     = sa ^ sb;
                    acc_next     = {(WIDTH+1)'(0), abs_a};
                    b_next       = abs_b;
                    bit_cnt_next = CNT_W'(WIDTH);
                    run_cnt_next = CNT_W'(1);
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (acc_reg[0]) begin
                    acc_next = {1'b0, sum, acc_reg[WIDTH-1:1]};
                end else begin
                    acc_next = acc_reg >> 1;
                end
                bit_cnt_next = bit_cnt_reg - CNT_W'(1);
                run_cnt_next = run_cnt_reg + CNT_W'(1);
                if (bit_cnt_reg == CNT_W'(1)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                product_next = signed_prod;
                cycles_next  = run_cnt_reg;
                done_next    = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign busy_o    = busy_reg;
    assign done_o    = done_reg;
    assign product_o = product_reg;
    assign cycles_o  = cycles_reg;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: directed corner cases plus random
// operations against an integer-arithmetic reference, at WIDTH=8 and WIDTH=4.
module tb_seq_mult_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, sgn;
    logic [7:0]  a, b;
    logic        busy, done;
    logic [15:0] product;
    logic [7:0]  cycles;

    logic        start4, sgn4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;
    logic [7:0]  cycles4;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_mult_param #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .start_i(start), .signed_i(sgn),
        .a_i(a), .b_i(b), .busy_o(busy), .done_o(done),
        .product_o(product), .cycles_o(cycles)
    );

    seq_mult_param #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .reset(reset), .start_i(start4), .signed_i(sgn4),
        .a_i(a4), .b_i(b4), .busy_o(busy4), .done_o(done4),
        .product_o(product4), .cycles_o(cycles4)
    );

    // Reference: interpret operands as integers and multiply, keep the low 2w bits.
    function automatic longint model_prod(int w, bit s, longint x, longint y);
        longint xv = x;
        longint yv = y;
        if (s && x[w-1]) xv = x - (longint'(1) << w);
        if (s && y[w-1]) yv = y - (longint'(1) << w);
        return (xv * yv) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Issues one op on the 8-bit unit; returns result, latency in edges after the start edge, busy cycles.
    task automatic run_op8(input bit s, input logic [7:0] ai, input logic [7:0] bi,
                           output logic [15:0] p, output logic [7:0] c,
                           output int lat, output int busy_cnt);
        start = 1'b1; sgn = s; a = ai; b = bi;
        @(posedge clk); #1;
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
        lat = 0; busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        p = product; c = cycles;
    endtask

    task automatic run_op4(input bit s, input logic [3:0] ai, input logic [3:0] bi,
                           output logic [7:0] p, output logic [7:0] c, output int lat);
        start4 = 1'b1; sgn4 = s; a4 = ai; b4 = bi;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = n;
                break;
            end
        end
        p = product4; c = cycles4;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, product, cycles} !== 26'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b product=%h cycles=%0d, required all zero",
                     busy, done, product, cycles);
        end
        tests_run++;
        if ({busy4, done4, product4, cycles4} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_state_w4: busy=%b done=%b product=%h cycles=%0d, required all zero",
                     busy4, done4, product4, cycles4);
        end
        reset = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_zero();
        logic [15:0] p; logic [7:0] c; int lat, bc;
        run_op8(1'b0, 8'd0, 8'd0, p, c, lat, bc);
        $display("[TB] zero: 0*0 -> %h cycles=%0d latency=%0d", p, c, lat);
        tests_run++;
        if (p !== 16'h0000) begin tests_failed++; $display("FAIL zero_product: got %h, required 0000", p); end
        tests_run++;
        if (c !== 8'd9) begin tests_failed++; $display("FAIL zero_cycles: got %0d, required 9", c); end
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("FAIL zero_latency: got %0d, required 9", lat); end
    endtask

    task automatic test_unsigned();
        logic [15:0] p; logic [7:0] c; int lat, bc;
        run_op8(1'b0, 8'd200, 8'd255, p, c, lat, bc);
        $display("[TB] unsigned: 200*255 -> %h busy_cycles=%0d latency=%0d", p, bc, lat);
        tests_run++;
        if (p !== 16'hC738) begin tests_failed++; $display("FAIL unsigned_product: got %h, required c738", p); end
        tests_run++;
        if (bc !== 9) begin tests_failed++; $display("FAIL unsigned_busy_len: got %0d, required 9", bc); end
        tests_run++;
        if (lat !== 9) begin tests_failed++; $display("FAIL unsigned_latency: got %0d, required 9", lat); end
        @(posedge clk); #1;
        tests_run++;
        if (done !== 1'b0 || product !== 16'hC738) begin
            tests_failed++;
            $display("FAIL done_single_pulse: done=%b product=%h, required done=0 product=c738", done, product);
        end
    endtask

    task automatic test_signed();
        bit          s_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  a_tab[4] = '{8'hFD, 8'h80, 8'h80, 8'h80};
        logic [7:0]  b_tab[4] = '{8'h05, 8'h80, 8'h7F, 8'h80};
        logic [15:0] e_tab[4] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h4000};
        logic [15:0] p; logic [7:0] c; int lat, bc;
        for (int i = 0; i < 4; i++) begin
            run_op8(s_tab[i], a_tab[i], b_tab[i], p, c, lat, bc);
            $display("[TB] signed=%0d %h*%h -> %h", s_tab[i], a_tab[i], b_tab[i], p);
            tests_run++;
            if (p !== e_tab[i]) begin
                tests_failed++;
                $display("FAIL signed_case%0d: got %h, required %h", i, p, e_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; logic [7:0] c; int lat, bc;
        int n_done;
        // First op 12*11; a second start with 7*9 is pulsed at E3 and must be dropped.
        start = 1'b1; sgn = 1'b0; a = 8'd12; b = 8'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; a = 8'd7; b = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int n = 4; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin n_done = n; break; end
        end
        $display("[TB] mid-op start ignored: 12*11 -> %h at edge %0d", product, n_done);
        tests_run++;
        if (product !== 16'(model_prod(8, 1'b0, 12, 11)) || n_done !== 9) begin
            tests_failed++;
            $display("FAIL midop_ignore: product=%h edge=%0d, required 0084 at edge 9", product, n_done);
        end
        // Start during the done cycle must be accepted.
        run_op8(1'b0, 8'd7, 8'd9, p, c, lat, bc);
        $display("[TB] back-to-back: 7*9 -> %h latency=%0d", p, lat);
        tests_run++;
        if (p !== 16'h003F || lat !== 9) begin
            tests_failed++;
            $display("FAIL back_to_back: product=%h latency=%0d, required 003f latency 9", p, lat);
        end
    endtask

    task automatic test_abort();
        int dones;
        start = 1'b1; sgn = 1'b0; a = 8'd100; b = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        $display("[TB] abort at E4: busy=%b done=%b product=%h", busy, done, product);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000 || cycles !== 8'd0) begin
            tests_failed++;
            $display("FAIL abort_state: busy=%b done=%b product=%h cycles=%0d, required all zero",
                     busy, done, product, cycles);
        end
        dones = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: saw %0d busy/done cycles, required 0", dones);
        end
    endtask

    task automatic test_random();
        logic [15:0] p; logic [7:0] c; int lat, bc;
        bit s; logic [7:0] ai, bi; logic [15:0] exp_p;
        for (int i = 0; i < 30; i++) begin
            s  = 1'($urandom);
            ai = 8'($urandom);
            bi = 8'($urandom);
            exp_p = 16'(model_prod(8, s, longint'(ai), longint'(bi)));
            run_op8(s, ai, bi, p, c, lat, bc);
            $display("[TB] random %0d: signed=%0d %h*%h -> %h (ref %h)", i, s, ai, bi, p, exp_p);
            tests_run++;
            if (p !== exp_p || c !== 8'd9 || lat !== 9) begin
                tests_failed++;
                $display("FAIL random%0d: product=%h cycles=%0d latency=%0d, required %h 9 9",
                         i, p, c, lat, exp_p);
            end
        end
    endtask

    task automatic test_width4();
        bit         s_tab[3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] a_tab[3] = '{4'hF, 4'h8, 4'h8};
        logic [3:0] b_tab[3] = '{4'hF, 4'h8, 4'h7};
        logic [7:0] e_tab[3] = '{8'hE1, 8'h40, 8'hC8};
        logic [7:0] p, c; int lat;
        bit s; logic [3:0] ai, bi; logic [7:0] exp_p;
        for (int i = 0; i < 3; i++) begin
            run_op4(s_tab[i], a_tab[i], b_tab[i], p, c, lat);
            $display("[TB] w4 signed=%0d %h*%h -> %h cycles=%0d", s_tab[i], a_tab[i], b_tab[i], p, c);
            tests_run++;
            if (p !== e_tab[i] || c !== 8'd5 || lat !== 5) begin
                tests_failed++;
                $display("FAIL w4_case%0d: product=%h cycles=%0d latency=%0d, required %h 5 5",
                         i, p, c, lat, e_tab[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            s  = 1'($urandom);
            ai = 4'($urandom);
            bi = 4'($urandom);
            exp_p = 8'(model_prod(4, s, longint'(ai), longint'(bi)));
            run_op4(s, ai, bi, p, c, lat);
            $display("[TB] w4 random %0d: signed=%0d %h*%h -> %h (ref %h)", i, s, ai, bi, p, exp_p);
            tests_run++;
            if (p !== exp_p || c !== 8'd5) begin
                tests_failed++;
                $display("FAIL w4_random%0d: product=%h cycles=%0d, required %h 5", i, p, c, exp_p);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
        test_reset();
        test_zero();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_abort();
        test_random();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
